idct_pipeline_ctrl: RTL and testbench



---
 rtl/idct_pkg.sv | 42 ++++
 rtl/idct_stage_wdog.sv | 38 +++
 rtl/idct_pipeline_ctrl.sv | 153 +++++++++++++++
 tb/tb_idct_pipeline_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// idct_pkg: shared definitions for the IDCT pipeline controller.
//   - default parameter values for idct_pipeline_ctrl
//   - controller FSM state encoding (state_t)
//   - stage-select encoding (stage_sel_t) and the state -> stage mapping
package idct_pkg;

    localparam int DEF_AW          = 18;
    localparam int DEF_IN_WORDS    = 64;
    localparam int DEF_OUT_WORDS   = 32;
    localparam int DEF_NBW         = 8;
    localparam int DEF_OUT_BASE    = 0;
    localparam int DEF_TIMEOUT_CYC = 4096;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        XFORM = 3'd2,
        STORE = 3'd3,
        NEXT  = 3'd4,
        FIN   = 3'd5
    } state_t;

    // Which external stage (if any) the controller is currently waiting on.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_LD   = 2'd1,
        SEL_TR   = 2'd2,
        SEL_ST   = 2'd3
    } stage_sel_t;

    function automatic stage_sel_t stage_of(input state_t s);
        stage_sel_t sel;
        case (s)
            LOAD:    sel = SEL_LD;
            XFORM:   sel = SEL_TR;
            STORE:   sel = SEL_ST;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/idct_stage_wdog.sv
// idct_stage_wdog: per-stage watchdog counter.
// Ports:
//   clock    in  rising-edge clock
//   reset_n  in  async active-low reset
//   clear    in  zero the counter (asserted the cycle before a stage is entered)
//   enable   in  count while a stage is waiting for its done
//   expired  out high once TIMEOUT_CYC cycles have been counted
// The counter is 0 on the first cycle of a stage, so expired rises after
// exactly TIMEOUT_CYC full cycles spent waiting. It saturates there.
module idct_stage_wdog
    import idct_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_reg;

    assign expired = (cnt_reg == CW'(TIMEOUT_CYC));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable && !expired) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/idct_pipeline_ctrl.sv
// idct_pipeline_ctrl: sequences load -> transform -> store for num_blocks
// blocks, generating one-cycle stage start pulses and per-block addresses.
// Ports:
//   clock, reset_n          clock / async active-low reset
//   start, num_blocks       run request (accepted in IDLE only) and block count
//   busy, done, error       run in progress / end-of-run pulse / sticky timeout
//   blk_idx                 current block index
//   ld_start, ld_done, ld_base   load stage handshake and base address
//   tr_start, tr_done            transform stage handshake
//   st_start, st_done, st_base   store stage handshake and base address
// Build option: define IDCT_WATCHDOG_EN to add a per-stage watchdog that
// aborts the run to FIN and raises error; otherwise stages wait forever.
module idct_pipeline_ctrl
    import idct_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int IN_WORDS    = DEF_IN_WORDS,
    parameter int OUT_WORDS   = DEF_OUT_WORDS,
    parameter int NBW         = DEF_NBW,
    parameter int OUT_BASE    = DEF_OUT_BASE,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic [NBW-1:0] num_blocks,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [NBW-1:0] blk_idx,
    output logic           ld_start,
    input  logic           ld_done,
    output logic [AW-1:0]  ld_base,
    output logic           tr_start,
    input  logic           tr_done,
    output logic           st_start,
    input  logic           st_done,
    output logic [AW-1:0]  st_base
);

    state_t         state_reg, state_next;
    logic           first_reg;      // high on the first cycle of any state
    logic [NBW-1:0] blk_idx_reg;
    logic [NBW-1:0] count_reg;
    stage_sel_t     sel;
    logic           accept;
    logic           stage_done;
    logic           wd_expired;
    logic           more_blocks;

    assign sel    = stage_of(state_reg);
    assign accept = (state_reg == IDLE) && start;

    // Only the done belonging to the current stage is looked at; the others
    // are ignored, which also covers done pulses seen while idle.
    always_comb begin
        stage_done = 1'b0;
        case (sel)
            SEL_LD:  stage_done = ld_done;
            SEL_TR:  stage_done = tr_done;
            SEL_ST:  stage_done = st_done;
            default: stage_done = 1'b0;
        endcase
    end

    assign more_blocks = ({1'b0, blk_idx_reg} + (NBW+1)'(1)) < {1'b0, count_reg};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            // An empty run still passes through NEXT (which then exits to
            // FIN without advancing), giving the same two-cycle start-to-done
            // latency as the shortest possible bookkeeping path.
            IDLE:  if (start) state_next = (num_blocks == '0) ? NEXT : LOAD;
            LOAD:  if (stage_done) state_next = XFORM;
                   else if (wd_expired) state_next = FIN;
            XFORM: if (stage_done) state_next = STORE;
                   else if (wd_expired) state_next = FIN;
            STORE: if (stage_done) state_next = NEXT;
                   else if (wd_expired) state_next = FIN;
            NEXT:  state_next = more_blocks ? LOAD : FIN;
            FIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            first_reg   <= 1'b0;
            blk_idx_reg <= '0;
            count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            first_reg <= (state_next != state_reg);
            if (accept) begin
                count_reg   <= num_blocks;
                blk_idx_reg <= '0;
            end else if ((state_reg == NEXT) && (count_reg != '0)) begin
                blk_idx_reg <= blk_idx_reg + NBW'(1);
            end
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == FIN);
    assign blk_idx  = blk_idx_reg;
    assign ld_start = (state_reg == LOAD)  && first_reg;
    assign tr_start = (state_reg == XFORM) && first_reg;
    assign st_start = (state_reg == STORE) && first_reg;

    // Addresses wrap modulo 2**AW. blk_idx only moves in NEXT or on start,
    // so both bases are steady for the whole LOAD..STORE span of a block.
    assign ld_base = AW'(32'(blk_idx_reg) * 32'(IN_WORDS));
    assign st_base = AW'(32'(OUT_BASE) + 32'(blk_idx_reg) * 32'(OUT_WORDS));

`ifdef IDCT_WATCHDOG_EN
    logic wd_clear;
    logic wd_enable;
    logic error_reg;

    // Clear one cycle ahead so the count reads 0 on a stage's first cycle.
    assign wd_clear  = (state_next != state_reg) && (stage_of(state_next) != SEL_NONE);
    assign wd_enable = (sel != SEL_NONE);

    idct_stage_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // A done arriving on the expiry cycle wins; error is not raised then.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            error_reg <= 1'b0;
        end else if (accept) begin
            error_reg <= 1'b0;
        end else if (wd_enable && !stage_done && wd_expired) begin
            error_reg <= 1'b1;
        end
    end

    assign error = error_reg;
`else
    assign wd_expired = 1'b0;
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_idct_pipeline_ctrl.sv
// Directed testbench for idct_pipeline_ctrl. A responder returns each stage
// done 5 cycles after its start (per-stage auto enables plus manual pulses),
// a monitor logs start/done cycles and base addresses, and every comparison
// goes through check_eq.
module tb_idct_pipeline_ctrl;

    localparam int AW  = 18;
    localparam int NBW = 8;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [NBW-1:0] num_blocks = '0;
    logic           busy, done, error;
    logic [NBW-1:0] blk_idx;
    logic           ld_start, tr_start, st_start;
    logic           ld_done = 1'b0, tr_done = 1'b0, st_done = 1'b0;
    logic [AW-1:0]  ld_base, st_base;

    idct_pipeline_ctrl #(
        .AW(AW), .IN_WORDS(64), .OUT_WORDS(32), .NBW(NBW),
        .OUT_BASE(0), .TIMEOUT_CYC(16)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .num_blocks(num_blocks),
        .busy(busy), .done(done), .error(error), .blk_idx(blk_idx),
        .ld_start(ld_start), .ld_done(ld_done), .ld_base(ld_base),
        .tr_start(tr_start), .tr_done(tr_done),
        .st_start(st_start), .st_done(st_done), .st_base(st_base)
    );

    initial forever #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int ld_cyc_q[$], tr_cyc_q[$], st_cyc_q[$], done_cyc_q[$];
    int ld_base_q[$], st_base_q[$];

    bit   auto_ld = 1'b1, auto_tr = 1'b1, auto_st = 1'b1;
    logic man_ld = 1'b0, man_tr = 1'b0, man_st = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Monitor: log every start/done pulse with its cycle number.
    initial forever begin
        @(negedge clock);
        if (ld_start) begin ld_cyc_q.push_back(cyc); ld_base_q.push_back(int'(ld_base)); end
        if (tr_start) tr_cyc_q.push_back(cyc);
        if (st_start) begin st_cyc_q.push_back(cyc); st_base_q.push_back(int'(st_base)); end
        if (done) done_cyc_q.push_back(cyc);
    end

    // Responder: done high during cycle c+5 for a start seen in cycle c.
    initial begin
        int ld_cnt = 0, tr_cnt = 0, st_cnt = 0;
        logic ld_p, tr_p, st_p;
        forever begin
            @(negedge clock);
            if (ld_start && auto_ld) ld_cnt = 5;
            if (tr_start && auto_tr) tr_cnt = 5;
            if (st_start && auto_st) st_cnt = 5;
            @(posedge clock);
            #1;
            ld_p = 1'b0; tr_p = 1'b0; st_p = 1'b0;
            if (ld_cnt > 0) begin ld_cnt--; ld_p = (ld_cnt == 0); end
            if (tr_cnt > 0) begin tr_cnt--; tr_p = (tr_cnt == 0); end
            if (st_cnt > 0) begin st_cnt--; st_p = (st_cnt == 0); end
            ld_done = ld_p | man_ld;
            tr_done = tr_p | man_tr;
            st_done = st_p | man_st;
        end
    end

    task automatic do_start(input int n, output int t);
        @(posedge clock);
        #1;
        start      = 1'b1;
        num_blocks = NBW'(n);
        t          = cyc;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int dcyc);
        int prev;
        prev = done_cyc_q.size();
        for (int i = 0; i < 300 && done_cyc_q.size() == prev; i++) @(negedge clock);
        check_eq(tag, done_cyc_q.size() - prev, 1);
        dcyc = qat(done_cyc_q, prev);
    endtask

    initial begin
        int t, t2, d, s, k, lp, tp, sp, dp, lbp, sbp;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_blk_idx", blk_idx, 0);
        check_eq("rst_starts", {ld_start, tr_start, st_start}, 0);
        check_eq("rst_ld_base", ld_base, 0);
        check_eq("rst_st_base", st_base, 0);
        @(posedge clock); #1 reset_n = 1'b1;
        repeat (2) @(posedge clock);

        // Three-block run
        lp = ld_cyc_q.size(); tp = tr_cyc_q.size(); dp = done_cyc_q.size();
        lbp = ld_base_q.size(); sbp = st_base_q.size();
        do_start(3, t);
        @(negedge clock);
        check_eq("run3_busy", busy, 1);
        wait_done("run3_done", d);
        check_eq("run3_ld_cnt", ld_cyc_q.size() - lp, 3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("run3_ld_base%0d", i), qat(ld_base_q, lbp + i), 64 * i);
            check_eq($sformatf("run3_st_base%0d", i), qat(st_base_q, sbp + i), 32 * i);
        end
        check_eq("run3_ld_lat", qat(ld_cyc_q, lp), t + 1);
        check_eq("run3_tr_lat", qat(tr_cyc_q, tp), qat(ld_cyc_q, lp) + 6);
        repeat (3) @(negedge clock);
        check_eq("run3_busy_after", busy, 0);
        check_eq("run3_blk_idx", blk_idx, 3);
        check_eq("run3_done_cnt", done_cyc_q.size() - dp, 1);

        // Empty run
        lp = ld_cyc_q.size(); tp = tr_cyc_q.size(); sp = st_cyc_q.size();
        do_start(0, t);
        wait_done("zero_done", d);
        check_eq("zero_done_cyc", d, t + 2);
        check_eq("zero_stage_starts",
                 (ld_cyc_q.size() - lp) + (tr_cyc_q.size() - tp) + (st_cyc_q.size() - sp), 0);
        check_eq("zero_blk_idx", blk_idx, 0);
        repeat (3) @(negedge clock);

        // Stray tr_done during LOAD
        auto_ld = 1'b0;
        lp = ld_cyc_q.size(); tp = tr_cyc_q.size();
        do_start(1, t);
        repeat (2) @(negedge clock);
        man_tr = 1'b1;
        @(negedge clock);
        man_tr = 1'b0;
        repeat (4) @(negedge clock);
        check_eq("stray_no_tr_start", tr_cyc_q.size() - tp, 0);
        check_eq("stray_busy", busy, 1);
        man_ld = 1'b1;
        k = cyc;
        @(negedge clock);
        man_ld = 1'b0;
        auto_ld = 1'b1;
        wait_done("stray_done", d);
        check_eq("stray_tr_lat", qat(tr_cyc_q, tp), k + 2);
        check_eq("stray_ld_cnt", ld_cyc_q.size() - lp, 1);
        repeat (3) @(negedge clock);

        // start re-asserted during STORE
        lp = ld_cyc_q.size(); sp = st_cyc_q.size(); dp = done_cyc_q.size();
        do_start(1, t);
        for (int i = 0; i < 100 && st_cyc_q.size() == sp; i++) @(negedge clock);
        do_start(5, t2);
        wait_done("store_start_done", d);
        repeat (10) @(negedge clock);
        check_eq("store_start_ld_cnt", ld_cyc_q.size() - lp, 1);
        check_eq("store_start_done_cnt", done_cyc_q.size() - dp, 1);
        check_eq("store_start_busy", busy, 0);

        // Reset during XFORM of block 1
        tp = tr_cyc_q.size();
        do_start(3, t);
        for (int i = 0; i < 200 && tr_cyc_q.size() < tp + 2; i++) @(negedge clock);
        check_eq("midrst_pre_blk", blk_idx, 1);
        dp = done_cyc_q.size();
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_blk_idx", blk_idx, 0);
        check_eq("midrst_ld_base", ld_base, 0);
        check_eq("midrst_st_base", st_base, 0);
        check_eq("midrst_flags", {done, error, ld_start, tr_start, st_start}, 0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (20) @(negedge clock);
        check_eq("midrst_no_done", done_cyc_q.size() - dp, 0);
        check_eq("midrst_busy_after", busy, 0);

`ifdef IDCT_WATCHDOG_EN
        // Watchdog: tr_done withheld, TIMEOUT_CYC = 16
        auto_tr = 1'b0;
        tp = tr_cyc_q.size();
        do_start(1, t);
        for (int i = 0; i < 100 && tr_cyc_q.size() == tp; i++) @(negedge clock);
        s = qat(tr_cyc_q, tp);
        wait_done("wdog_done", d);
        check_eq("wdog_done_cyc", d, s + 17);
        check_eq("wdog_error", error, 1);
        repeat (3) @(negedge clock);
        check_eq("wdog_error_hold", error, 1);
        auto_tr = 1'b1;
        do_start(1, t2);
        @(negedge clock);
        check_eq("wdog_error_clear", error, 0);
        wait_done("wdog_rerun_done", d);
`else
        // No watchdog: a withheld tr_done stalls the run indefinitely
        auto_tr = 1'b0;
        dp = done_cyc_q.size();
        do_start(1, t);
        repeat (40) @(negedge clock);
        check_eq("nowd_busy", busy, 1);
        check_eq("nowd_error", error, 0);
        check_eq("nowd_no_done", done_cyc_q.size() - dp, 0);
        s = 0;
        man_tr = 1'b1;
        @(negedge clock);
        man_tr = 1'b0;
        auto_tr = 1'b1;
        wait_done("nowd_done", d);
        check_eq("nowd_error_end", error, 0);
`endif

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
